// File: rtl/ft245_pkg.sv
// Shared types and constants for the FT245 synchronous-FIFO bus arbiter.
package ft245_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RX_OE   = 3'd1,
    RX_RD   = 3'd2,
    RX_TURN = 3'd3,
    TX      = 3'd4
  } ft_state_e;

  localparam logic FT_ASSERT   = 1'b0;
  localparam logic FT_DEASSERT = 1'b1;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 32;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ft245_rx_skid.sv
// Two-entry first-word-fall-through FIFO buffering bytes read from the FT chip.
module ft245_rx_skid
  import ft245_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [BYTE_W-1:0] push_data,
  input  logic              pop,
  output logic [BYTE_W-1:0] pop_data,
  output logic              full,
  output logic              empty
);

  logic [BYTE_W-1:0] mem_r [2];
  logic              wr_ptr_r;
  logic              rd_ptr_r;
  logic [1:0]        count_r;
  logic              do_push_s;
  logic              do_pop_s;

  assign do_push_s = push && (count_r != 2'd2);
  assign do_pop_s  = pop && (count_r != 2'd0);

  // Storage has no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      count_r  <= 2'd0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (do_pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
    end
  end

  assign pop_data = mem_r[rd_ptr_r];
  assign full     = (count_r == 2'd2);
  assign empty    = (count_r == 2'd0);

endmodule

// File: rtl/ft245_sync_bus_arbiter.sv
// Time-shares the FT2232H FT245 synchronous bus between the TX and RX streams
// with round-robin arbitration and per-direction burst limits.
module ft245_sync_bus_arbiter
  import ft245_pkg::*;
#(
  parameter int TX_BURST_MAX = 64,
  parameter int RX_BURST_MAX = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              rxf_i,
  input  logic              txe_i,
  input  logic [BYTE_W-1:0] adbus_i,
  output logic [BYTE_W-1:0] adbus_o,
  output logic              adbus_oe_o,
  output logic              oe_o,
  output logic              rd_o,
  output logic              wr_o,
  input  logic [BYTE_W-1:0] tx_data_i,
  input  logic              tx_valid_i,
  output logic              tx_ready_o,
  output logic [BYTE_W-1:0] rx_data_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic [CNT_W-1:0]  tx_bytes_o,
  output logic [CNT_W-1:0]  rx_bytes_o
);

  localparam int BURST_W = $clog2(max_int(TX_BURST_MAX, RX_BURST_MAX)) + 1;
  localparam logic [BURST_W-1:0] TX_LAST = BURST_W'(TX_BURST_MAX - 1);
  localparam logic [BURST_W-1:0] RX_LAST = BURST_W'(RX_BURST_MAX - 1);

  ft_state_e          state_r;
  logic [BURST_W-1:0] burst_cnt_r;
  logic               last_grant_rx_r;
  logic [CNT_W-1:0]   tx_bytes_r;
  logic [CNT_W-1:0]   rx_bytes_r;

  logic skid_full_s;
  logic skid_empty_s;
  logic rx_req_s;
  logic tx_req_s;
  logic rd_fire_s;
  logic wr_fire_s;

  assign rx_req_s  = !rxf_i && !skid_full_s;
  assign tx_req_s  = tx_valid_i && !txe_i;
  // Strobes follow the FT flags combinationally so a flag change never loses a byte.
  assign rd_fire_s = (state_r == RX_RD) && rx_req_s;
  assign wr_fire_s = (state_r == TX) && tx_req_s;

  assign rd_o       = rd_fire_s ? FT_ASSERT : FT_DEASSERT;
  assign wr_o       = wr_fire_s ? FT_ASSERT : FT_DEASSERT;
  assign tx_ready_o = wr_fire_s;
  assign oe_o       = ((state_r == RX_OE) || (state_r == RX_RD)) ? FT_ASSERT : FT_DEASSERT;
  assign adbus_oe_o = (state_r == TX);
  assign adbus_o    = tx_data_i;
  assign tx_bytes_o = tx_bytes_r;
  assign rx_bytes_o = rx_bytes_r;
  assign rx_valid_o = !skid_empty_s;

  // Bus sequencing, arbitration and byte counting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r         <= IDLE;
      burst_cnt_r     <= '0;
      last_grant_rx_r <= 1'b0;
      tx_bytes_r      <= '0;
      rx_bytes_r      <= '0;
    end else begin
      case (state_r)
        IDLE: begin
          burst_cnt_r <= '0;
          if (rx_req_s && (!tx_req_s || !last_grant_rx_r)) begin
            state_r <= RX_OE;
          end else if (tx_req_s) begin
            state_r <= TX;
          end else begin
            state_r <= IDLE;
          end
        end
        RX_OE: begin
          state_r <= RX_RD;
        end
        RX_RD: begin
          if (rd_fire_s) begin
            rx_bytes_r  <= rx_bytes_r + CNT_W'(1);
            burst_cnt_r <= burst_cnt_r + BURST_W'(1);
          end
          if (!rx_req_s || (burst_cnt_r == RX_LAST)) begin
            state_r         <= RX_TURN;
            last_grant_rx_r <= 1'b1;
          end
        end
        RX_TURN: begin
          state_r <= IDLE;
        end
        TX: begin
          if (wr_fire_s) begin
            tx_bytes_r  <= tx_bytes_r + CNT_W'(1);
            burst_cnt_r <= burst_cnt_r + BURST_W'(1);
          end
          if (!tx_req_s || (burst_cnt_r == TX_LAST)) begin
            state_r         <= IDLE;
            last_grant_rx_r <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
        end
      endcase
    end
  end

  ft245_rx_skid u_rx_skid (
    .clk       (clk_i),
    .rst       (rst_i),
    .push      (rd_fire_s),
    .push_data (adbus_i),
    .pop       (rx_valid_o && rx_ready_i),
    .pop_data  (rx_data_o),
    .full      (skid_full_s),
    .empty     (skid_empty_s)
  );

endmodule

// File: tb/tb_ft245_sync_bus_arbiter.sv
// Self-checking bench: FT chip model plus user-side scoreboards for both streams.
module tb_ft245_sync_bus_arbiter;

  logic        clk_i;
  logic        rst_i;
  logic        rxf_i;
  logic        txe_i;
  logic [7:0]  adbus_i;
  logic [7:0]  adbus_o;
  logic        adbus_oe_o;
  logic        oe_o;
  logic        rd_o;
  logic        wr_o;
  logic [7:0]  tx_data_i;
  logic        tx_valid_i;
  logic        tx_ready_o;
  logic [7:0]  rx_data_o;
  logic        rx_valid_o;
  logic        rx_ready_i;
  logic [31:0] tx_bytes_o;
  logic [31:0] rx_bytes_o;

  ft245_sync_bus_arbiter #(.TX_BURST_MAX(4), .RX_BURST_MAX(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .rxf_i(rxf_i), .txe_i(txe_i),
    .adbus_i(adbus_i), .adbus_o(adbus_o), .adbus_oe_o(adbus_oe_o),
    .oe_o(oe_o), .rd_o(rd_o), .wr_o(wr_o),
    .tx_data_i(tx_data_i), .tx_valid_i(tx_valid_i), .tx_ready_o(tx_ready_o),
    .rx_data_o(rx_data_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .tx_bytes_o(tx_bytes_o), .rx_bytes_o(rx_bytes_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    int          n_tx;
    logic [7:0]  tx_base;
    int          n_rx;
    logic [7:0]  rx_base;
    int          stall_after;
    int          stall_len;
    logic [31:0] exp_tx_total;
    logic [31:0] exp_rx_total;
    int          exp_wr_low;
  } vec_t;

  vec_t vecs [3];

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] ft_rx_q [$];
  logic [7:0] exp_rx_q [$];
  logic [7:0] tx_src_q [$];
  logic [7:0] exp_tx_q [$];

  int   stall_left  = 0;
  int   stall_after = -1;
  int   stall_len   = 0;
  int   wr_count    = 0;
  int   wr_low_cnt  = 0;
  int   rd_low_cnt  = 0;
  logic prev_oe     = 1'b1;
  bit   arb_on      = 1'b0;
  int   cur_kind    = 0;
  int   run_len     = 0;
  int   runs_q [$];
  int   kinds_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flush();
    ft_rx_q.delete();
    exp_rx_q.delete();
    tx_src_q.delete();
    exp_tx_q.delete();
  endtask

  task automatic drive_inputs(input logic rst);
    rst_i      = rst;
    rxf_i      = (ft_rx_q.size() == 0);
    adbus_i    = (ft_rx_q.size() != 0) ? ft_rx_q[0] : 8'h00;
    txe_i      = (stall_left > 0);
    tx_valid_i = (tx_src_q.size() != 0);
    tx_data_i  = (tx_src_q.size() != 0) ? tx_src_q[0] : 8'h00;
  endtask

  // One clock: drive at negedge, sample 1 ns later, resolve the handshakes of the next posedge.
  task automatic tick(input logic rst);
    bit stalled;
    int kind;
    drive_inputs(rst);
    #1;
    stalled = (stall_left > 0);
    kind = 0;
    if (!rst) begin
      check("oe_vs_drive", 32'(oe_o == 1'b0 && adbus_oe_o == 1'b1), 32'd0);
      if (stalled) check("stall_wr_high", 32'(wr_o), 32'd1);
      if (rd_o == 1'b0) begin
        kind = 1;
        rd_low_cnt++;
        check("rd_needs_oe", 32'({prev_oe, oe_o, rxf_i}), 32'd0);
        if (ft_rx_q.size() != 0) void'(ft_rx_q.pop_front());
      end
      if (wr_o == 1'b0) begin
        kind = 2;
        wr_low_cnt++;
        wr_count++;
        check("wr_handshake", 32'({tx_ready_o, adbus_oe_o, txe_i}), 32'd6);
        if (exp_tx_q.size() == 0) check("tx_extra_byte", 32'd1, 32'd0);
        else check("tx_byte", 32'(adbus_o), 32'(exp_tx_q.pop_front()));
      end
      if (tx_valid_i && tx_ready_o) void'(tx_src_q.pop_front());
      if (rx_valid_o && rx_ready_i) begin
        if (exp_rx_q.size() == 0) check("rx_extra_byte", 32'd1, 32'd0);
        else check("rx_byte", 32'(rx_data_o), 32'(exp_rx_q.pop_front()));
      end
      if (arb_on && kind != 0) begin
        if (kind == cur_kind) begin
          run_len++;
        end else begin
          if (cur_kind != 0) runs_q.push_back(run_len);
          cur_kind = kind;
          run_len = 1;
          kinds_q.push_back(kind);
        end
      end
    end
    prev_oe = oe_o;
    @(posedge clk_i);
    @(negedge clk_i);
    if (stalled) stall_left--;
    if (kind == 2 && wr_count == stall_after) stall_left = stall_len;
  endtask

  task automatic run_until_done(input int budget, input string name);
    int n;
    n = 0;
    while ((tx_src_q.size() != 0 || exp_tx_q.size() != 0 || exp_rx_q.size() != 0 ||
            ft_rx_q.size() != 0) && n < budget) begin
      tick(1'b0);
      n++;
    end
    if (n >= budget) begin
      check({name, "_timeout"}, 32'd1, 32'd0);
      flush();
    end
  endtask

  task automatic load(input int n_tx, input logic [7:0] tx_base,
                      input int n_rx, input logic [7:0] rx_base);
    for (int i = 0; i < n_tx; i++) begin
      tx_src_q.push_back(tx_base + 8'(i));
      exp_tx_q.push_back(tx_base + 8'(i));
    end
    for (int i = 0; i < n_rx; i++) begin
      ft_rx_q.push_back(rx_base + 8'(i));
      exp_rx_q.push_back(rx_base + 8'(i));
    end
  endtask

  initial begin
    vecs[0] = '{"tx_only",  10, 8'h00, 0,  8'h00, -1, 0, 32'd10, 32'd0,  10};
    vecs[1] = '{"tx_stall", 8,  8'h10, 0,  8'h00, 4,  3, 32'd18, 32'd0,  8};
    vecs[2] = '{"mixed",    12, 8'h20, 12, 8'h80, -1, 0, 32'd30, 32'd12, 12};

    rx_ready_i = 1'b0;
    drive_inputs(1'b1);
    @(negedge clk_i);

    // Reset with both sides requesting.
    ft_rx_q.push_back(8'h55);
    tx_src_q.push_back(8'h66);
    tick(1'b1);
    tick(1'b1);
    drive_inputs(1'b1);
    #1;
    check("reset_oe", 32'(oe_o), 32'd1);
    check("reset_rd", 32'(rd_o), 32'd1);
    check("reset_wr", 32'(wr_o), 32'd1);
    check("reset_adbus_oe", 32'(adbus_oe_o), 32'd0);
    check("reset_tx_ready", 32'(tx_ready_o), 32'd0);
    check("reset_rx_valid", 32'(rx_valid_o), 32'd0);
    check("reset_tx_bytes", tx_bytes_o, 32'd0);
    check("reset_rx_bytes", rx_bytes_o, 32'd0);
    flush();
    rx_ready_i = 1'b1;

    for (int v = 0; v < 3; v++) begin
      wr_low_cnt  = 0;
      wr_count    = 0;
      stall_after = vecs[v].stall_after;
      stall_len   = vecs[v].stall_len;
      load(vecs[v].n_tx, vecs[v].tx_base, vecs[v].n_rx, vecs[v].rx_base);
      run_until_done(300, vecs[v].name);
      repeat (2) tick(1'b0);
      check({vecs[v].name, "_tx_bytes"}, tx_bytes_o, vecs[v].exp_tx_total);
      check({vecs[v].name, "_rx_bytes"}, rx_bytes_o, vecs[v].exp_rx_total);
      check({vecs[v].name, "_wr_low"}, 32'(wr_low_cnt), 32'(vecs[v].exp_wr_low));
    end
    stall_after = -1;

    // RX backpressure: skid fills after two reads and holds the rest in the chip.
    rx_ready_i = 1'b0;
    rd_low_cnt = 0;
    load(0, 8'h00, 6, 8'hA0);
    repeat (10) tick(1'b0);
    check("bp_rd_low", 32'(rd_low_cnt), 32'd2);
    check("bp_rx_valid", 32'(rx_valid_o), 32'd1);
    check("bp_head", 32'(rx_data_o), 32'hA0);
    check("bp_ft_left", 32'(ft_rx_q.size()), 32'd4);
    rx_ready_i = 1'b1;
    run_until_done(200, "bp_drain");
    check("bp_rx_bytes", rx_bytes_o, 32'd18);
    check("bp_rd_total", 32'(rd_low_cnt), 32'd6);

    // Reset in the middle of an RX burst.
    rd_low_cnt = 0;
    load(0, 8'h00, 8, 8'h60);
    for (int n = 0; n < 50 && rd_low_cnt < 2; n++) tick(1'b0);
    check("mid_rst_started", 32'(rd_low_cnt), 32'd2);
    tick(1'b1);
    flush();
    drive_inputs(1'b0);
    #1;
    check("mid_rst_oe", 32'(oe_o), 32'd1);
    check("mid_rst_rd", 32'(rd_o), 32'd1);
    check("mid_rst_adbus_oe", 32'(adbus_oe_o), 32'd0);
    check("mid_rst_rx_valid", 32'(rx_valid_o), 32'd0);
    check("mid_rst_rx_bytes", rx_bytes_o, 32'd0);
    check("mid_rst_tx_bytes", tx_bytes_o, 32'd0);

    // Arbitration with both sides continuously pending right after reset.
    arb_on = 1'b1;
    load(16, 8'h40, 16, 8'hC0);
    run_until_done(400, "arb");
    if (cur_kind != 0) runs_q.push_back(run_len);
    arb_on = 1'b0;
    check("arb_run_count", 32'(runs_q.size()), 32'd8);
    if (kinds_q.size() != 0) check("arb_rx_first", 32'(kinds_q[0]), 32'd1);
    else check("arb_rx_first", 32'd0, 32'd1);
    foreach (runs_q[i]) check("arb_run_len", 32'(runs_q[i]), 32'd4);
    for (int i = 1; i < kinds_q.size(); i++)
      check("arb_alternate", 32'(kinds_q[i]), 32'(3 - kinds_q[i-1]));
    check("arb_tx_bytes", tx_bytes_o, 32'd16);
    check("arb_rx_bytes", rx_bytes_o, 32'd16);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ft245_sync_bus_arbiter.md
Name: ft245_sync_bus_arbiter

Overview:
Owns the FT2232H FT245 synchronous-FIFO bus and time-shares it between the TX stream (FPGA->PC) and the RX stream (PC->FPGA).
It sequences OE#/RD#/WR#, handles data-bus turnaround, and applies round-robin arbitration with per-direction burst limits.
It sits between the FT2232H pins (clocked by the chip's 60 MHz CLKOUT) and user-side valid/ready streams, such as the counter streamer and a command decoder.

Parameters:
TX_BURST_MAX, 64, max bytes written per TX grant before re-arbitration (>=1)
RX_BURST_MAX, 64, max bytes read per RX grant before re-arbitration (>=1)

Ports:
clk_i  in  1  FT2232H CLKOUT; all logic on rising edge
rst_i  in  1  synchronous reset, active-high
rxf_i  in  1  FT RXF#, active-low; low = PC data available
txe_i  in  1  FT TXE#, active-low; low = chip FIFO has space
adbus_i  in  8  ADBUS input (sampled during reads)
adbus_o  out  8  ADBUS output data
adbus_oe_o  out  1  high = FPGA drives ADBUS
oe_o  out  1  FT OE#, active-low
rd_o  out  1  FT RD#, active-low
wr_o  out  1  FT WR#, active-low
tx_data_i  in  8  user TX byte
tx_valid_i  in  1  TX byte valid
tx_ready_o  out  1  TX byte accepted this edge when valid&ready
rx_data_o  out  8  user RX byte
rx_valid_o  out  1  RX byte valid
rx_ready_i  in  1  user accepts RX byte
tx_bytes_o  out  32  bytes written to FT, wraps at 2^32
rx_bytes_o  out  32  bytes read from FT, wraps at 2^32

Behaviour:
- Reset (rst_i=1 at an edge):
  - state=IDLE; oe_o=1, rd_o=1, wr_o=1, adbus_oe_o=0, tx_ready_o=0.
  - RX skid FIFO emptied, so rx_valid_o=0.
  - Counters cleared to 0. last_grant=TX, so RX wins the first tie.
  - Reset mid-burst aborts immediately. An RX byte being sampled on the reset edge is discarded.
- States: IDLE, RX_OE, RX_RD, RX_TURN, TX.
- Definitions: rx_req = !rxf_i && !skid_full; tx_req = tx_valid_i && !txe_i.
- IDLE transitions:
  - rx_req && (!tx_req || last_grant==TX) -> RX_OE.
  - Otherwise tx_req -> TX.
  - Otherwise stay.
  - burst_cnt cleared on any exit.
- RX_OE: oe_o=0, rd_o=1, one cycle of turnaround; always -> RX_RD.
- RX_RD:
  - oe_o=0; rd_o = !(rx_req) (combinational).
  - Byte adbus_i pushed into the skid on every edge where rd_o=0; rx_bytes_o++, burst_cnt++.
  - Exit -> RX_TURN when rxf_i=1, skid_full, or burst_cnt reaches RX_BURST_MAX (on the edge of the last byte). last_grant<=RX.
- RX_TURN: oe_o=1, adbus_oe_o=0, one cycle so the FT releases ADBUS; -> IDLE.
- TX:
  - adbus_oe_o=1; adbus_o=tx_data_i.
  - wr_o = !(tx_req) (combinational); tx_ready_o = tx_req.
  - Byte transferred on each edge where wr_o=0; tx_bytes_o++, burst_cnt++.
  - Exit -> IDLE when !tx_req or burst_cnt reaches TX_BURST_MAX. last_grant<=TX.
  - TXE# rising mid-burst: wr_o goes high in the same cycle, so no byte is lost or duplicated.
- In every state other than TX, adbus_oe_o=0 and tx_ready_o=0.
- oe_o and adbus_oe_o are decoded from the state register only, so they are never low/high simultaneously.
- The RX skid FIFO is 2 entries, first-word fall-through.
  - rx_valid_o = !empty.
  - Pop on rx_valid_o && rx_ready_i.
  - Simultaneous push/pop when full is not allowed (rd_o is blocked while full).
- Latency: TX 0 cycles (valid to wr_o). RX: byte visible on rx_data_o the cycle after the sampling edge. Grant overhead: RX 2 cycles (RX_OE + RX_TURN), TX 0 extra cycles.
- burst_cnt width is $clog2(max(TX_BURST_MAX,RX_BURST_MAX))+1.

Decomposition:
- Package ft245_pkg holds:
  - The state enum (IDLE, RX_OE, RX_RD, RX_TURN, TX).
  - FT_ASSERT=1'b0 and FT_DEASSERT=1'b1.
  - Byte width 8 and counter width 32.
- Sub-module ft245_rx_skid: 2-entry FWFT FIFO with push/pop/full/empty.

Test Plan:
- Reset: rst_i=1 for 2 cycles with rxf_i=0, tx_valid_i=1 -> oe_o=rd_o=wr_o=1, adbus_oe_o=0, rx_valid_o=0, both counters 0.
- TX only: txe_i=0, rxf_i=1, 10 bytes 0x00..0x09 -> wr_o low 10 cycles, bytes in order, tx_bytes_o=10, adbus_oe_o=1 only in TX.
- TX stall: TXE# high for 3 cycles after byte 4 of 8 -> wr_o high those 3 cycles, byte 4 sent exactly once, tx_bytes_o=8.
- RX backpressure: rxf_i=0 with 6 bytes 0xA0..0xA5, rx_ready_i=0 -> rd_o low 2 cycles then high, skid full. Then rx_ready_i=1 -> all 6 delivered in order, rx_bytes_o=6.
- Arbitration: RX_BURST_MAX=4, TX_BURST_MAX=4, both sides continuously pending -> RX first. Pattern RX4, TURN, TX4, RX4... RX_OE precedes every RD, and oe_o=0 never coincides with adbus_oe_o=1.
- Reset mid-RX burst (after 2 bytes) -> next cycle oe_o=1, rd_o=1, skid empty, state IDLE.
